// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register numbers, exception encodings, reset values and bit positions.
// Also provides the excepttype decoder used by cp0_reg_multi.
package cp0_defs;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam logic [31:0] EXCTYPE_INT     = 32'h0000_0001;
    localparam logic [31:0] EXCTYPE_ADEL    = 32'h0000_0004;
    localparam logic [31:0] EXCTYPE_ADES    = 32'h0000_0005;
    localparam logic [31:0] EXCTYPE_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXCTYPE_RI      = 32'h0000_000a;
    localparam logic [31:0] EXCTYPE_OV      = 32'h0000_000c;
    localparam logic [31:0] EXCTYPE_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXCTYPE_ERET    = 32'h0000_000e;

    localparam logic [4:0] EXCCODE_INT     = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL    = 5'h04;
    localparam logic [4:0] EXCCODE_ADES    = 5'h05;
    localparam logic [4:0] EXCCODE_SYSCALL = 5'h08;
    localparam logic [4:0] EXCCODE_RI      = 5'h0a;
    localparam logic [4:0] EXCCODE_OV      = 5'h0c;
    localparam logic [4:0] EXCCODE_TRAP    = 5'h0d;

    localparam logic [31:0] STATUS_RST = 32'h1000_0000;
    localparam logic [31:0] CONFIG_RST = 32'h0000_8000;
    localparam logic [31:0] PRID_RST   = 32'h004C_0102;

    localparam int STATUS_IE      = 0;
    localparam int STATUS_EXL     = 1;
    localparam int STATUS_IM_LO   = 8;
    localparam int CAUSE_IP_LO    = 8;
    localparam int CAUSE_EXC_LO   = 2;
    localparam int CAUSE_BD       = 31;
    localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

    typedef struct packed {
        logic       valid;
        logic [4:0] code;
    } exc_dec_t;

    function automatic exc_dec_t exc_decode(input logic [31:0] etype, input logic addr_en);
        exc_dec_t d;
        d.valid = 1'b1;
        d.code  = EXCCODE_INT;
        case (etype)
            EXCTYPE_INT:     d.code = EXCCODE_INT;
            EXCTYPE_SYSCALL: d.code = EXCCODE_SYSCALL;
            EXCTYPE_RI:      d.code = EXCCODE_RI;
            EXCTYPE_OV:      d.code = EXCCODE_OV;
            EXCTYPE_TRAP:    d.code = EXCCODE_TRAP;
            EXCTYPE_ADEL: begin
                d.valid = addr_en;
                d.code  = EXCCODE_ADEL;
            end
            EXCTYPE_ADES: begin
                d.valid = addr_en;
                d.code  = EXCCODE_ADES;
            end
            default:         d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cp0_timer_chan.sv
// One Count/Compare channel: holds its compare value and a sticky pending flag.
// A write to the channel clears the flag and takes priority over a same-cycle match.
module cp0_timer_chan (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [31:0] count,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] compare,
    output logic        pending
);

    logic hit_s;

    assign hit_s = tick && (count == compare) && (compare != 32'h0000_0000);

    // Compare register and sticky match flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            compare <= 32'h0000_0000;
            pending <= 1'b0;
        end else if (we) begin
            compare <= wdata;
            pending <= 1'b0;
        end else if (hit_s) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_reg_multi.sv
// CP0 register file with multiple compare channels, Count prescaler and synchronised interrupts.
// Optional BadVAddr support is enabled with the CP0_BADVADDR_EN macro.
module cp0_reg_multi
    import cp0_defs::*;
#(
    parameter int NUM_TIMERS  = 1,
    parameter int NUM_HW_INT  = 6,
    parameter int COUNT_DIV   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [2:0]            wsel_i,
    input  logic [4:0]            raddr_i,
    input  logic [2:0]            rsel_i,
    input  logic [31:0]           data_i,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic [31:0]           excepttype_i,
    input  logic [31:0]           current_inst_addr_i,
    input  logic                  is_in_delayslot_i,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0]           bad_addr_i,
    output logic [31:0]           badvaddr_o,
`endif
    output logic [31:0]           data_o,
    output logic [31:0]           count_o,
    output logic [31:0]           compare_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           config_o,
    output logic [31:0]           prid_o,
    output logic [NUM_TIMERS-1:0] timer_int_o,
    output logic                  int_req_o
);

`ifdef CP0_BADVADDR_EN
    localparam logic ADDR_EXC_EN = 1'b1;
`else
    localparam logic ADDR_EXC_EN = 1'b0;
`endif
    localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

    logic [3:0]            presc_r, presc_n_s;
    logic [31:0]           count_r, count_n_s;
    logic [31:0]           status_r, status_n_s, status_w_s;
    logic [31:0]           cause_r, cause_n_s, cause_w_s;
    logic [31:0]           epc_r, epc_n_s, epc_w_s;
    logic [31:0]           config_r, prid_r;
    logic                  int_req_r;
    logic                  tick_s, wr_sel0_s, wr_count_s, upd_epc_s;
    logic [NUM_HW_INT-1:0] int_sync_s;
    logic [5:0]            hw_ip_s;
    logic [31:0]           compare_s [NUM_TIMERS];
    logic [31:0]           rd_cmp_s, rd_base_s, exc_pc_s;
    exc_dec_t              exc_s;

    assign tick_s     = (presc_r == DIV_LAST);
    assign wr_sel0_s  = we_i && (wsel_i == 3'd0);
    assign wr_count_s = wr_sel0_s && (waddr_i == REG_COUNT);
    assign exc_s      = exc_decode(excepttype_i, ADDR_EXC_EN);
    assign upd_epc_s  = exc_s.valid && !status_r[STATUS_EXL];
    assign exc_pc_s   = is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign int_sync_s = int_i;
        end else begin : g_sync
            logic [NUM_HW_INT-1:0] sync_r [SYNC_STAGES];

            // Metastability chain for the asynchronous interrupt levels
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
                end else begin
                    sync_r[0] <= int_i;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
                end
            end

            assign int_sync_s = sync_r[SYNC_STAGES-1];
        end

        for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_timer
            cp0_timer_chan u_chan (
                .clk     (clk),
                .rst     (rst),
                .tick    (tick_s),
                .count   (count_r),
                .we      (we_i && (waddr_i == REG_COMPARE) && (wsel_i == 3'(k))),
                .wdata   (data_i),
                .compare (compare_s[k]),
                .pending (timer_int_o[k])
            );
        end
    endgenerate

    assign hw_ip_s = 6'(int_sync_s);

    // Count write restarts the prescaler phase and beats a same-cycle tick
    always_comb begin
        if (wr_count_s) begin
            presc_n_s = 4'd0;
            count_n_s = data_i;
        end else if (tick_s) begin
            presc_n_s = 4'd0;
            count_n_s = count_r + 32'd1;
        end else begin
            presc_n_s = presc_r + 4'd1;
            count_n_s = count_r;
        end
    end

    assign status_w_s = (wr_sel0_s && (waddr_i == REG_STATUS)) ? data_i : status_r;
    assign epc_w_s    = (wr_sel0_s && (waddr_i == REG_EPC)) ? data_i : epc_r;
    assign cause_w_s  = (wr_sel0_s && (waddr_i == REG_CAUSE))
                      ? ((cause_r & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK)) : cause_r;

    // Exception/eret overlay on top of the mtc0 result; exception fields win
    always_comb begin
        status_n_s = status_w_s;
        cause_n_s  = cause_w_s;
        epc_n_s    = epc_w_s;
        cause_n_s[15:10] = {hw_ip_s[5] | (|timer_int_o), hw_ip_s[4:0]};
        if (upd_epc_s) begin
            epc_n_s             = exc_pc_s;
            cause_n_s[CAUSE_BD] = is_in_delayslot_i;
        end else begin
            epc_n_s = epc_w_s;
        end
        if (exc_s.valid) begin
            status_n_s[STATUS_EXL]              = 1'b1;
            cause_n_s[CAUSE_EXC_LO +: 5]        = exc_s.code;
        end else if (excepttype_i == EXCTYPE_ERET) begin
            status_n_s[STATUS_EXL] = 1'b0;
        end else begin
            status_n_s[STATUS_EXL] = status_w_s[STATUS_EXL];
        end
    end

    // Architectural state and registered interrupt request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r   <= 4'd0;
            count_r   <= 32'h0000_0000;
            status_r  <= STATUS_RST;
            cause_r   <= 32'h0000_0000;
            epc_r     <= 32'h0000_0000;
            config_r  <= CONFIG_RST;
            prid_r    <= PRID_RST;
            int_req_r <= 1'b0;
        end else begin
            presc_r   <= presc_n_s;
            count_r   <= count_n_s;
            status_r  <= status_n_s;
            cause_r   <= cause_n_s;
            epc_r     <= epc_n_s;
            int_req_r <= status_r[STATUS_IE] & ~status_r[STATUS_EXL]
                       & (|(cause_r[CAUSE_IP_LO +: 8] & status_r[STATUS_IM_LO +: 8]));
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_r;

    // Faulting address capture, independent of EXL
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr_r <= 32'h0000_0000;
        end else if ((excepttype_i == EXCTYPE_ADEL) || (excepttype_i == EXCTYPE_ADES)) begin
            badvaddr_r <= bad_addr_i;
        end
    end

    assign badvaddr_o = badvaddr_r;
`endif

    // Compare channel selected by rsel; out-of-range selects read 0
    always_comb begin
        rd_cmp_s = 32'h0000_0000;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            rd_cmp_s = (rsel_i == 3'(k)) ? compare_s[k] : rd_cmp_s;
        end
    end

    // Select-0 registers
    always_comb begin
        case (raddr_i)
            REG_COUNT:    rd_base_s = count_r;
            REG_STATUS:   rd_base_s = status_r;
            REG_CAUSE:    rd_base_s = cause_r;
            REG_EPC:      rd_base_s = epc_r;
            REG_PRID:     rd_base_s = prid_r;
            REG_CONFIG:   rd_base_s = config_r;
`ifdef CP0_BADVADDR_EN
            REG_BADVADDR: rd_base_s = badvaddr_r;
`endif
            default:      rd_base_s = 32'h0000_0000;
        endcase
    end

    assign data_o = (raddr_i == REG_COMPARE) ? rd_cmp_s
                  : ((rsel_i == 3'd0) ? rd_base_s : 32'h0000_0000);

    assign count_o   = count_r;
    assign compare_o = compare_s[0];
    assign status_o  = status_r;
    assign cause_o   = cause_r;
    assign epc_o     = epc_r;
    assign config_o  = config_r;
    assign prid_o    = prid_r;
    assign int_req_o = int_req_r;

endmodule
